noc_merge2: RTL

- Clocked 2-to-1 merge stage that sits directly downstream of the binary routing decoder in the tree NoC.
- Consumes the decoder's two output flit streams, or one decoder output and a sibling node's output.
- Arbitrates round-robin, buffers in a small output FIFO, and emits one flit stream toward the next tree level.
- Tags each output flit with the input it came from, mirroring the decoder's select side-channel.

---
 rtl/noc_pkg.sv | 19 +
 rtl/noc_flit_fifo.sv | 70 +++++++
 rtl/noc_merge2.sv | 92 +++++++++
 3 files changed

// File: rtl/noc_pkg.sv
// Shared tree-NoC types: flit layout and the decoder/merge source-select encoding.
package noc_pkg;

  localparam int unsigned FLIT_W   = 9;
  localparam int unsigned ADDR_MSB = 8;
  localparam int unsigned ADDR_LSB = 5;

  typedef logic [FLIT_W-1:0] flit_t;

  // Same encoding as the decoder's select side-channel.
  typedef logic src_t;
  localparam src_t SrcIn0 = 1'b0;
  localparam src_t SrcIn1 = 1'b1;

  function automatic logic [ADDR_MSB-ADDR_LSB:0] flit_addr(input flit_t flit);
    return flit[ADDR_MSB:ADDR_LSB];
  endfunction

endpackage

// File: rtl/noc_flit_fifo.sv
// Synchronous flit FIFO with occupancy count; storage is cleared on reset so the
// head reads as zero while empty after reset.
module noc_flit_fifo #(
  parameter int unsigned Width = 10,
  parameter int unsigned Depth = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       push_i,
  input  logic [Width-1:0]           wdata_i,
  input  logic                       pop_i,
  output logic [Width-1:0]           rdata_o,
  output logic                       empty_o,
  output logic                       full_o,
  output logic [$clog2(Depth+1)-1:0] count_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = $clog2(Depth + 1);
  localparam logic [CntW-1:0] DepthCnt = CntW'(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wptr_q, rptr_q;
  logic [CntW-1:0]  count_q, count_d;
  logic             push_ok, pop_ok;

  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;

  always_comb begin
    count_d = count_q;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Depth is a power of two, so pointer overflow is the modulo wrap.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      for (int unsigned i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (push_ok) begin
        mem_q[wptr_q] <= wdata_i;
        wptr_q        <= wptr_q + 1'b1;
      end
      if (pop_ok) begin
        rptr_q <= rptr_q + 1'b1;
      end
      count_q <= count_d;
    end
  end

  assign rdata_o = mem_q[rptr_q];
  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == DepthCnt);
  assign count_o = count_q;

`ifndef SYNTHESIS
  a_no_push_when_full: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(push_i && full_o));
`endif

endmodule

// File: rtl/noc_merge2.sv
// 2-to-1 round-robin merge into a small output FIFO; each buffered flit carries the
// index of the input it arrived on.
module noc_merge2
  import noc_pkg::*;
#(
  parameter int unsigned W     = FLIT_W,
  parameter int unsigned DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [W-1:0]               in0_data,
  input  logic                       in0_valid,
  output logic                       in0_ready,
  input  logic [W-1:0]               in1_data,
  input  logic                       in1_valid,
  output logic                       in1_ready,
  output logic [W-1:0]               out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       out_src,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned CntW = $clog2(DEPTH + 1);

  src_t         rr_q, rr_d;
  logic         grant0, grant1;
  logic         acc0, acc1;
  logic         full, empty;
  logic         push, pop;
  src_t         push_src;
  logic [W:0]   fifo_wdata, fifo_rdata;

  assign grant0 = in0_valid & (~in1_valid | (rr_q == SrcIn0));
  assign grant1 = in1_valid & (~in0_valid | (rr_q == SrcIn1));

  // A full FIFO blocks both inputs even when it is being popped this cycle.
  assign acc0 = grant0 & ~full;
  assign acc1 = grant1 & ~full;

  assign in0_ready = rst_n & acc0;
  assign in1_ready = rst_n & acc1;

  assign push       = acc0 | acc1;
  assign push_src   = acc1 ? SrcIn1 : SrcIn0;
  assign fifo_wdata = {push_src, (acc1 ? in1_data : in0_data)};
  assign pop        = ~empty & out_ready;

  always_comb begin
    rr_d = rr_q;
    if (acc0) begin
      rr_d = SrcIn1;
    end else if (acc1) begin
      rr_d = SrcIn0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q <= SrcIn0;
    end else begin
      rr_q <= rr_d;
    end
  end

  noc_flit_fifo #(
    .Width (W + 1),
    .Depth (DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .push_i  (push),
    .wdata_i (fifo_wdata),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .empty_o (empty),
    .full_o  (full),
    .count_o (count)
  );

  assign out_valid = ~empty;
  assign out_src   = fifo_rdata[W];
  assign out_data  = fifo_rdata[W-1:0];

`ifndef SYNTHESIS
  a_one_ready: assert property (@(posedge clk) disable iff (!rst_n)
    !(in0_ready && in1_ready));
  a_count_bound: assert property (@(posedge clk) disable iff (!rst_n)
    count <= CntW'(DEPTH));
`endif

endmodule
